// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter driving a shared data path with a registered grant FSM.
// Optional per-grant transfer limit enabled by defining ARB_TIMEOUT_EN (limit set by MAX_HOLD).
module mux_arbiter #(
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   input  logic             out_ready,
   output logic             gnt0,
   output logic             gnt1,
   output logic             select,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic [15:0]      xfer_count
);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

   state_t state, state_nxt;
   logic   last_served;
   logic   xfer;
   logic   hold_done;

   assign out_data  = select ? data1 : data0;
   assign out_valid = (gnt0 & req0) | (gnt1 & req1);
   assign xfer      = out_valid & out_ready;

`ifdef ARB_TIMEOUT_EN
   localparam int HW = $clog2(MAX_HOLD + 1);
   logic [HW-1:0] hold_cnt;

   // Counter saturates at MAX_HOLD, so any later transfer still qualifies for hand-over.
   assign hold_done = xfer && (hold_cnt >= HW'(MAX_HOLD - 1));
`else
   assign hold_done = 1'b0;
   if (MAX_HOLD < 1) begin : g_max_hold_unused
   end
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req0 && req1)  state_nxt = last_served ? GRANT0 : GRANT1;
            else if (req0)     state_nxt = GRANT0;
            else if (req1)     state_nxt = GRANT1;
         end
         GRANT0: begin
            if (!req0)                 state_nxt = req1 ? GRANT1 : IDLE;
            else if (hold_done && req1) state_nxt = GRANT1;
         end
         GRANT1: begin
            if (!req1)                 state_nxt = req0 ? GRANT0 : IDLE;
            else if (hold_done && req0) state_nxt = GRANT0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         gnt0        <= 1'b0;
         gnt1        <= 1'b0;
         select      <= 1'b0;
         last_served <= 1'b1;
         xfer_count  <= '0;
`ifdef ARB_TIMEOUT_EN
         hold_cnt    <= '0;
`endif
      end else begin
         state <= state_nxt;
         gnt0  <= (state_nxt == GRANT0);
         gnt1  <= (state_nxt == GRANT1);
         // select and last_served only move on grant entry; IDLE keeps the old path.
         if (state_nxt != IDLE) select <= (state_nxt == GRANT1);
         if (state_nxt != state && state_nxt != IDLE) last_served <= (state_nxt == GRANT1);
         if (xfer) xfer_count <= xfer_count + 16'd1;
`ifdef ARB_TIMEOUT_EN
         if (state_nxt != state)                           hold_cnt <= '0;
         else if (xfer && hold_cnt != HW'(MAX_HOLD))       hold_cnt <= hold_cnt + 1'b1;
`endif
      end
   end

endmodule
